axis_mux_pkt: RTL
=================

Name: axis_mux_pkt

Overview:
- Parametrised N:1 AXI-Stream multiplexer that switches only on packet boundaries. It is the successor to the 16-input combinational point-to-point mux that feeds the shared inner-product core.
- One-hot channel select is sampled only between packets. The grant is held until the granted input's tlast beat is accepted.
- Only the granted input sees tready, so non-selected producers are never drained by accident.
- The output is registered through a 2-entry skid buffer, giving full throughput, no combinational tready path from master to slaves, and clean timing closure at DATA_W=128.

Parameters:
- N_CH, 16, number of slave inputs (2..32).
- DATA_W, 128, tdata width in bits (multiple of 8).
- KEEP_W, DATA_W/8, tkeep width (derived; do not override).
- CH_W, $clog2(N_CH), channel index width (derived).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- s_axis_tvalid  in  N_CH  per-channel valid.
- s_axis_tready  out  N_CH  per-channel ready.
- s_axis_tdata  in  N_CH*DATA_W  channel i at bits [i*DATA_W +: DATA_W].
- s_axis_tkeep  in  N_CH*KEEP_W  channel i at bits [i*KEEP_W +: KEEP_W].
- s_axis_tlast  in  N_CH  per-channel last.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tdata  out  DATA_W  output data.
- m_axis_tkeep  out  KEEP_W  output keep.
- m_axis_tlast  out  1  output last.
- sel  in  N_CH  one-hot requested channel.
- busy  out  1  1 while a packet is locked (state PASS).
- cur_ch  out  CH_W  index of the granted channel; valid while busy.
- sel_err  out  1  one-cycle pulse when sel is sampled and is not one-hot and not all-zero.
- pkt_cnt  out  32  output packet count (see Optional Feature).

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, grant=0, busy=0, cur_ch=0, sel_err=0.
  - Skid buffer is emptied: m_axis_tvalid=0; m_axis_tdata, tkeep and tlast are 0.
  - All s_axis_tready are 0; pkt_cnt=0.
  - Reset mid-packet discards both buffered beats and the lock. The remainder of the interrupted packet is not reassembled; upstream must also be reset.
- State IDLE:
  - Every s_axis_tready is 0.
  - sel is sampled each cycle.
  - If sel is one-hot: grant<=sel, cur_ch<=encoded index, and PASS is entered next cycle.
  - If sel is all-zero: stay in IDLE, no error.
  - If sel is multi-hot: stay in IDLE and pulse sel_err for 1 cycle, repeating each cycle the condition persists.
- State PASS:
  - s_axis_tready[cur_ch] = skid buffer not full. Every other s_axis_tready = 0.
  - A slave beat is accepted when s_axis_tvalid[cur_ch] and s_axis_tready[cur_ch] are both 1.
  - The accepted beat's tdata, tkeep and tlast are written to the skid buffer.
  - Changes to sel while in PASS are ignored.
  - When the accepted beat has tlast=1:
    - If sel is one-hot in that same cycle, re-grant directly: load grant and cur_ch, stay in PASS. Back-to-back packets have zero bubble, including a switch to a different channel.
    - Otherwise return to IDLE next cycle. A multi-hot sel in that cycle also pulses sel_err.
- Skid buffer:
  - Depth is 2.
  - A beat accepted at edge k appears on m_axis at cycle k+1 when the buffer was empty (latency 1).
  - m_axis_tvalid=1 whenever the buffer holds at least 1 entry.
  - An output beat is popped when m_axis_tvalid and m_axis_tready are both 1.
  - Push and pop in the same cycle leave the occupancy unchanged.
  - With m_axis_tready held at 1, the buffer sustains 1 beat per clock.
  - Full (2 entries) drops the granted tready; it reasserts the cycle after a pop.
  - m_axis_tdata, tkeep and tlast are stable while m_axis_tvalid=1 and m_axis_tready=0.
- tkeep and tdata pass through unmodified. There is no width conversion.

Optional Feature:
- Macro: AXIS_MUX_PKT_CNT_EN.
- When defined: pkt_cnt is a 32-bit register.
  - It increments on each m-side handshake with m_axis_tlast=1 and wraps from 0xFFFFFFFF to 0.
  - It is cleared by rst.
- When undefined: pkt_cnt is tied to 0 and no counter logic is synthesised.

Decomposition:
- Shared package axis_mux_pkt_pkg:
  - state enum {IDLE, PASS};
  - function onehot_check(vec) returning {is_onehot, is_zero};
  - function onehot_to_idx(vec).
- One sub-module: axis_skid_buf (parameter WIDTH = DATA_W+KEEP_W+1; 2-entry, valid/ready both sides). The rest of the codebase reuses it.

Test Plan:
- Reset and idle: rst for 3 cycles, then sel=16'h0000 with all s_tvalid=1 → m_axis_tvalid=0, all s_tready=0, busy=0.
- Single packet: sel=16'h0004; ch2 sends 4 beats 0x..01..0x..04 with tlast on beat 4, m_tready=1:
  - first m_tvalid appears 1 cycle after the first slave accept;
  - the 4 beats arrive in order;
  - busy drops after the tlast beat.
- Mid-packet sel change: ch5 packet of 8 beats; sel switches to 16'h0200 at beat 3 → all 8 ch5 beats are output, then ch9 is granted; s_tready[9]=0 until the ch5 tlast beat is accepted.
- Back-pressure: m_tready=0 for 5 cycles during a ch0 stream → exactly 2 beats are buffered, s_tready[0]=0, and m_tdata holds stable. Release → no beat is lost or duplicated.
- Back-to-back switch with zero bubble: ch1 1-beat packet, sel=16'h0008 during its tlast beat → the ch3 beat is accepted the next cycle and the m-side beats are contiguous.
- Invalid select: sel=16'h0011 → sel_err=1 each cycle, no grant. With AXIS_MUX_PKT_CNT_EN defined, pkt_cnt=3 after 3 packets.

Source files
------------

// File: rtl/axis_mux_pkt_pkg.sv
// Shared types and helpers for the packet-boundary AXI-Stream mux.
// FSM state encodings and one-hot select decoding.
package axis_mux_pkt_pkg;

    localparam int MAX_CH = 32;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] PASS = 1'b1;

    // Returns {is_onehot, is_zero} for a select vector.
    function automatic logic [1:0] onehot_check(input logic [MAX_CH-1:0] vec);
        logic is_zero;
        logic is_onehot;
        is_zero   = (vec == '0);
        is_onehot = !is_zero && ((vec & (vec - 32'd1)) == '0);
        return {is_onehot, is_zero};
    endfunction

    // Index of the set bit; meaningful only for a one-hot input.
    function automatic logic [4:0] onehot_to_idx(input logic [MAX_CH-1:0] vec);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (vec[i]) begin
                idx = 5'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry registered skid buffer with valid/ready on both sides.
// Input ready depends only on occupancy, so no ready path crosses it.
module axis_skid_buf #(
    parameter int WIDTH = 145
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    logic [1:0]       r_cnt;
    logic [WIDTH-1:0] r_d0;
    logic [WIDTH-1:0] r_d1;
    logic             w_push;
    logic             w_pop;

    assign o_ready = (r_cnt != 2'd2);
    assign o_valid = (r_cnt != 2'd0);
    assign o_data  = r_d0;
    assign w_push  = i_valid && o_ready;
    assign w_pop   = o_valid && i_ready;

    // Occupancy and storage: r_d0 is always the head beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 2'd0;
            r_d0  <= '0;
            r_d1  <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) begin
                        r_d0 <= i_data;
                    end else begin
                        r_d1 <= i_data;
                    end
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    if (r_cnt == 2'd2) begin
                        r_d0 <= r_d1;
                    end
                    r_cnt <= r_cnt - 2'd1;
                end
                2'b11: begin
                    // Push needs cnt<2 and pop needs cnt>0, so cnt is 1 here.
                    r_d0 <= i_data;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/axis_mux_pkt.sv
// N:1 AXI-Stream mux that switches channels only on packet boundaries.
// Optional packet counter enabled by AXIS_MUX_PKT_CNT_EN.
module axis_mux_pkt
    import axis_mux_pkt_pkg::*;
#(
    parameter int N_CH   = 16,
    parameter int DATA_W = 128
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_CH-1:0]              s_axis_tvalid,
    output logic [N_CH-1:0]              s_axis_tready,
    input  logic [N_CH*DATA_W-1:0]       s_axis_tdata,
    input  logic [N_CH*(DATA_W/8)-1:0]   s_axis_tkeep,
    input  logic [N_CH-1:0]              s_axis_tlast,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic [DATA_W-1:0]            m_axis_tdata,
    output logic [DATA_W/8-1:0]          m_axis_tkeep,
    output logic                         m_axis_tlast,
    input  logic [N_CH-1:0]              sel,
    output logic                         busy,
    output logic [$clog2(N_CH)-1:0]      cur_ch,
    output logic                         sel_err,
    output logic [31:0]                  pkt_cnt
);

    localparam int KEEP_W = DATA_W / 8;
    localparam int CH_W   = $clog2(N_CH);
    localparam int SKID_W = DATA_W + KEEP_W + 1;

    logic [0:0]        r_state;
    logic [N_CH-1:0]   r_grant;
    logic [CH_W-1:0]   r_cur_ch;
    logic              r_sel_err;

    logic [MAX_CH-1:0] w_sel_ext;
    logic [1:0]        w_sel_chk;
    logic              w_sel_one;
    logic              w_sel_multi;
    logic              w_pass;
    logic              w_skid_ready;
    logic              w_acc;
    logic              w_last;
    logic [SKID_W-1:0] w_s_beat;
    logic [SKID_W-1:0] w_m_beat;

    assign w_sel_ext   = MAX_CH'(sel);
    assign w_sel_chk   = onehot_check(w_sel_ext);
    assign w_sel_one   = w_sel_chk[1];
    assign w_sel_multi = !w_sel_chk[1] && !w_sel_chk[0];

    assign w_pass = (r_state == PASS);
    assign w_last = s_axis_tlast[r_cur_ch];
    assign w_acc  = w_pass && s_axis_tvalid[r_cur_ch] && w_skid_ready;

    assign w_s_beat = {
        s_axis_tlast[r_cur_ch],
        s_axis_tkeep[r_cur_ch*KEEP_W +: KEEP_W],
        s_axis_tdata[r_cur_ch*DATA_W +: DATA_W]
    };

    // Only the locked channel ever sees ready.
    assign s_axis_tready = (w_pass && w_skid_ready) ? r_grant : '0;

    assign busy    = w_pass;
    assign cur_ch  = r_cur_ch;
    assign sel_err = r_sel_err;

    // Grant FSM: lock on a one-hot select, release or re-grant on tlast.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_cur_ch  <= '0;
            r_sel_err <= 1'b0;
        end else begin
            r_sel_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_sel_one) begin
                        r_grant  <= sel;
                        r_cur_ch <= CH_W'(onehot_to_idx(w_sel_ext));
                        r_state  <= PASS;
                    end else if (w_sel_multi) begin
                        r_sel_err <= 1'b1;
                    end
                end
                PASS: begin
                    if (w_acc && w_last) begin
                        if (w_sel_one) begin
                            r_grant  <= sel;
                            r_cur_ch <= CH_W'(onehot_to_idx(w_sel_ext));
                        end else begin
                            r_state   <= IDLE;
                            r_grant   <= '0;
                            r_sel_err <= w_sel_multi;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    axis_skid_buf #(
        .WIDTH (SKID_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_acc),
        .o_ready (w_skid_ready),
        .i_data  (w_s_beat),
        .o_valid (m_axis_tvalid),
        .i_ready (m_axis_tready),
        .o_data  (w_m_beat)
    );

    assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = w_m_beat;

`ifdef AXIS_MUX_PKT_CNT_EN
    logic [31:0] r_pkt_cnt;

    // Count packets leaving on the master side; wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pkt_cnt <= 32'd0;
        end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
            r_pkt_cnt <= r_pkt_cnt + 32'd1;
        end
    end

    assign pkt_cnt = r_pkt_cnt;
`else
    assign pkt_cnt = 32'd0;
`endif

endmodule
